adc_data_lane_align: RTL and testbench
======================================

# adc_data_lane_align

Data-lane stage directly downstream of frame alignment in the ADC LVDS receive path. It fans the frame aligner's bitslip pulse out to every data-lane deserializer so all lanes slip in lockstep with the frame lane. After frame alignment it verifies a known ADC test pattern on every lane and declares lock. It then delivers registered, validated parallel samples and keeps per-lane error statistics.

## Interface
- `AdcBits`, 14, sample width per lane. Legal values are 8, 10, 12 and 14.
- `Lanes`, 2, number of data lanes.
- `TestPattern`, 16'h2A5A, expected lane word in pattern mode. Only bits [AdcBits-1:0] are compared.
- `SettleCycles`, 8, cycles to wait after FrmAlignDone rises. Range 1–255.
- `LockCycles`, 64, consecutive all-lane pattern matches required for lock. Range 1–65535.
- `DatClkDiv`, in, 1, the single clock. Same net as the deserializer CLKDIV.
- `DatRst`, in, 1, reset: synchronous, active-high.
- `FrmBitslip`, in, 1, bitslip pulse from the frame aligner.
- `FrmAlignDone`, in, 1, frame-aligned status from the frame aligner.
- `DatPatMode`, in, 1, 1 = ADC is emitting TestPattern and checking is enabled; 0 = normal data.
- `DatLaneIn`, in, Lanes*AdcBits, parallel deserializer outputs. Lane k occupies bits [k*AdcBits +: AdcBits].
- `DatBitslip`, out, Lanes, bitslip to each lane deserializer.
- `DatSample`, out, Lanes*AdcBits, registered samples. Same lane packing as DatLaneIn.
- `DatValid`, out, 1, DatSample is valid this cycle.
- `DatLocked`, out, 1, state is RUN.
- `DatErr`, out, Lanes, sticky per-lane pattern-mismatch flags.
- `DatErrCnt`, out, 16, count of cycles with any lane mismatch in RUN. Saturates at 16'hFFFF.

## Operation
- Bitslip fan-out:
  - DatBitslip = {Lanes{FrmBitslip}}, combinational.
  - Forced to 0 while DatRst=1.
  - Not gated by state, so data lanes slip in the same DatClkDiv cycle as the frame deserializer.
- Match definition: lane k matches when DatLaneIn[k*AdcBits +: AdcBits] == TestPattern[AdcBits-1:0]. AllMatch is the AND over all lanes.
- State machine, four states:
  - IDLE: remain while FrmAlignDone=0. Go to SETTLE when FrmAlignDone=1.
  - SETTLE: the settle counter counts SettleCycles cycles. On expiry, go to CHECK if DatPatMode=1, otherwise go to RUN. Entering SETTLE clears DatErr and DatErrCnt.
  - CHECK:
    - On an AllMatch cycle, increment the match counter.
    - On any mismatch, set the matching DatErr bit(s) and clear the match counter to 0.
    - When the counter reaches LockCycles, go to RUN.
    - If DatPatMode drops to 0, go to RUN.
  - RUN:
    - DatLocked=1 and DatValid=1.
    - If DatPatMode=1, every cycle with a lane mismatch sets the corresponding DatErr bit(s) and increments DatErrCnt by 1, saturating.
    - If DatPatMode=0, no error accounting.
- Global exit: FrmAlignDone=0 in any non-IDLE state moves to IDLE on the next edge. This has priority over every other transition. Counters are cleared. DatErr and DatErrCnt are kept.
- FrmBitslip=1 while in SETTLE, CHECK or RUN forces a move to IDLE, with the same treatment as FrmAlignDone=0.
- Data path: DatSample is registered from DatLaneIn every cycle in RUN. Outside RUN, DatSample holds its last value.

## Timing
- Reset values:
  - State = IDLE.
  - DatSample = 0, DatValid = 0, DatLocked = 0.
  - DatErr = 0, DatErrCnt = 0.
  - DatBitslip = 0.
  - All internal counters = 0.
- DatRst mid-operation: on the next edge all of the above values are restored, regardless of state.
- FrmAlignDone sampled 1 at edge t gives SETTLE from t+1.
- In SETTLE, the transition out occurs at edge t+1+SettleCycles.
- CHECK with continuous matches: RUN is entered LockCycles edges after CHECK entry.
- DatValid and DatLocked rise on the same edge that enters RUN.
- Sample latency: DatSample and DatValid reflect DatLaneIn from the previous edge (1 cycle).
- DatErr and DatErrCnt update 1 cycle after the mismatching input.
- Simultaneous match-counter completion and FrmAlignDone=0: IDLE wins.
- DatErrCnt at 16'hFFFF with another mismatch stays at 16'hFFFF.

## Test plan
- **Reset:** hold DatRst 3 cycles with FrmAlignDone=1 and FrmBitslip=1 -> all outputs 0, including DatBitslip; state IDLE.
- **Bitslip fan-out:** Lanes=2, FrmBitslip pulses at cycles 10 and 15 -> DatBitslip=2'b11 in exactly those cycles, 0 otherwise.
- **Lock, pattern mode:**
  - Stimulus: DatPatMode=1, both lanes 14'h2A5A, FrmAlignDone rises at cycle 20.
  - Expected: SETTLE from 21; CHECK from 29; DatLocked=DatValid=1 from cycle 93; DatErr=0.
- **Mismatch restarts CHECK:**
  - Stimulus: in CHECK after 40 matches, lane 1 = 14'h0000 for one cycle.
  - Expected: DatErr=2'b10; lock needs a further 64 consecutive matches.
- **RUN error counting:**
  - Stimulus: in RUN, lane 0 corrupted for 5 cycles.
  - Expected: DatErrCnt=5, DatErr=2'b01, DatValid stays 1. With the counter preset near full, verify it saturates at 16'hFFFF.
- **Loss of alignment and normal mode:**
  - Stimulus: FrmAlignDone drops in RUN.
  - Expected: DatValid=0 and DatLocked=0 next cycle; DatErrCnt kept.
  - Stimulus: re-align with DatPatMode=0.
  - Expected: RUN directly after SETTLE, at cycle t+9; DatSample equals DatLaneIn delayed by 1 cycle.

Source files
------------

// File: rtl/adc_data_lane_align.sv
// ADC LVDS data-lane stage: bitslip fan-out, test-pattern lock,
// registered sample delivery and per-lane error statistics.
module adc_data_lane_align #(
  parameter int          AdcBits      = 14,
  parameter int          Lanes        = 2,
  parameter logic [15:0] TestPattern  = 16'h2A5A,
  parameter int          SettleCycles = 8,
  parameter int          LockCycles   = 64
) (
  input  logic                     DatClkDiv,
  input  logic                     DatRst,
  input  logic                     FrmBitslip,
  input  logic                     FrmAlignDone,
  input  logic                     DatPatMode,
  input  logic [Lanes*AdcBits-1:0] DatLaneIn,
  output logic [Lanes-1:0]         DatBitslip,
  output logic [Lanes*AdcBits-1:0] DatSample,
  output logic                     DatValid,
  output logic                     DatLocked,
  output logic [Lanes-1:0]         DatErr,
  output logic [15:0]              DatErrCnt
);

  typedef enum logic [1:0] {
    Idle,
    Settle,
    Check,
    Run
  } state_t;

  localparam logic [AdcBits-1:0] Pat = TestPattern[AdcBits-1:0];
  localparam logic [7:0]  SettleLast = 8'(SettleCycles - 1);
  localparam logic [15:0] LockLast   = 16'(LockCycles - 1);

  state_t      state;
  state_t      stateNext;
  logic [7:0]  settleCnt;
  logic [7:0]  settleCntNext;
  logic [15:0] matchCnt;
  logic [15:0] matchCntNext;
  logic [Lanes-1:0] laneMiss;
  logic        allMatch;
  logic        abort;
  logic        errUpd;
  logic        errClr;
  logic        cntUpd;

  // Data lanes slip in the same cycle as the frame lane
  assign DatBitslip = DatRst ? '0 : {Lanes{FrmBitslip}};

  assign DatLocked = (state == Run);
  assign DatValid  = (state == Run);

  // Per-lane comparison against the ADC test pattern
  always_comb begin
    laneMiss = '0;
    for (int k = 0; k < Lanes; k++) begin
      laneMiss[k] = (DatLaneIn[k*AdcBits +: AdcBits] != Pat);
    end
  end

  assign allMatch = ~|laneMiss;

  // Next-state, counter and error-accounting decode
  always_comb begin
    stateNext     = state;
    settleCntNext = settleCnt;
    matchCntNext  = matchCnt;
    errUpd        = 1'b0;
    errClr        = 1'b0;
    cntUpd        = 1'b0;
    abort = (state != Idle) && (!FrmAlignDone || FrmBitslip);
    if (abort) begin
      stateNext     = Idle;
      settleCntNext = '0;
      matchCntNext  = '0;
    end else begin
      unique case (state)
        Idle: begin
          if (FrmAlignDone) begin
            stateNext     = Settle;
            settleCntNext = '0;
            errClr        = 1'b1;
          end
        end
        Settle: begin
          if (settleCnt == SettleLast) begin
            settleCntNext = '0;
            matchCntNext  = '0;
            stateNext     = DatPatMode ? Check : Run;
          end else begin
            settleCntNext = settleCnt + 8'd1;
          end
        end
        Check: begin
          if (!DatPatMode) begin
            stateNext    = Run;
            matchCntNext = '0;
          end else if (allMatch) begin
            if (matchCnt == LockLast) begin
              stateNext    = Run;
              matchCntNext = '0;
            end else begin
              matchCntNext = matchCnt + 16'd1;
            end
          end else begin
            matchCntNext = '0;
            errUpd       = 1'b1;
          end
        end
        Run: begin
          if (DatPatMode && !allMatch) begin
            errUpd = 1'b1;
            cntUpd = 1'b1;
          end
        end
        default: stateNext = Idle;
      endcase
    end
  end

  // State and lock counters
  always_ff @(posedge DatClkDiv) begin
    if (DatRst) begin
      state     <= Idle;
      settleCnt <= '0;
      matchCnt  <= '0;
    end else begin
      state     <= stateNext;
      settleCnt <= settleCntNext;
      matchCnt  <= matchCntNext;
    end
  end

  // Sticky lane errors and saturating RUN error count
  always_ff @(posedge DatClkDiv) begin
    if (DatRst) begin
      DatErr    <= '0;
      DatErrCnt <= '0;
    end else if (errClr) begin
      DatErr    <= '0;
      DatErrCnt <= '0;
    end else begin
      if (errUpd) begin
        DatErr <= DatErr | laneMiss;
      end
      if (cntUpd && (DatErrCnt != 16'hFFFF)) begin
        DatErrCnt <= DatErrCnt + 16'd1;
      end
    end
  end

  // Capture on every edge that leaves the block in RUN
  always_ff @(posedge DatClkDiv) begin
    if (DatRst) begin
      DatSample <= '0;
    end else if (stateNext == Run) begin
      DatSample <= DatLaneIn;
    end
  end

endmodule

// File: tb/tb_adc_data_lane_align.sv
// Bench for adc_data_lane_align: directed stimulus, sample
// scoreboard checked by a separate monitor process.
module tb_adc_data_lane_align;

  localparam logic [13:0] P = 14'h2A5A;

  logic        DatClkDiv = 1'b0;
  logic        DatRst;
  logic        FrmBitslip;
  logic        FrmAlignDone;
  logic        DatPatMode;
  logic [27:0] DatLaneIn;
  logic [1:0]  DatBitslip;
  logic [27:0] DatSample;
  logic        DatValid;
  logic        DatLocked;
  logic [1:0]  DatErr;
  logic [15:0] DatErrCnt;

  int nChk  = 0;
  int nFail = 0;
  logic [27:0] expQ[$];
  logic [27:0] expS;
  logic [13:0] vals [8] = '{14'h0000, 14'h3FFF, 14'h1555, 14'h2AAA,
                            14'h0001, 14'h2000, 14'h1234, 14'h3A5A};

  adc_data_lane_align dut (
    .DatClkDiv    (DatClkDiv),
    .DatRst       (DatRst),
    .FrmBitslip   (FrmBitslip),
    .FrmAlignDone (FrmAlignDone),
    .DatPatMode   (DatPatMode),
    .DatLaneIn    (DatLaneIn),
    .DatBitslip   (DatBitslip),
    .DatSample    (DatSample),
    .DatValid     (DatValid),
    .DatLocked    (DatLocked),
    .DatErr       (DatErr),
    .DatErrCnt    (DatErrCnt)
  );

  always #5 DatClkDiv = ~DatClkDiv;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge DatClkDiv);
    #1;
  endtask

  task automatic cyc(input logic [13:0] l0, input logic [13:0] l1,
                     input bit push);
    DatLaneIn = {l1, l0};
    if (push) expQ.push_back({l1, l0});
    tick();
  endtask

  // Monitor: every valid sample must match the oldest expectation
  always @(negedge DatClkDiv) begin
    if (DatValid === 1'b1) begin
      if (expQ.size() == 0) begin
        nChk++;
        nFail++;
        $display("FAIL sample: got %0h with valid, expected no valid",
                 DatSample);
      end else begin
        expS = expQ.pop_front();
        chk("sample", {4'h0, DatSample}, {4'h0, expS});
      end
    end
  end

  initial begin
    DatRst       = 1'b1;
    FrmBitslip   = 1'b1;
    FrmAlignDone = 1'b1;
    DatPatMode   = 1'b0;
    DatLaneIn    = '0;
    repeat (3) tick();
    chk("rst bitslip", {30'h0, DatBitslip}, 32'h0);
    chk("rst valid", {31'h0, DatValid}, 32'h0);
    chk("rst locked", {31'h0, DatLocked}, 32'h0);
    chk("rst sample", {4'h0, DatSample}, 32'h0);
    chk("rst err", {30'h0, DatErr}, 32'h0);
    chk("rst errcnt", {16'h0, DatErrCnt}, 32'h0);
    DatRst       = 1'b0;
    FrmBitslip   = 1'b0;
    FrmAlignDone = 1'b0;
    tick();

    for (int c = 0; c < 20; c++) begin
      FrmBitslip = (c == 10) || (c == 15);
      #1;
      chk("bitslip fanout", {30'h0, DatBitslip},
          FrmBitslip ? 32'h3 : 32'h0);
      tick();
    end
    FrmBitslip = 1'b0;
    chk("idle locked", {31'h0, DatLocked}, 32'h0);

    DatPatMode   = 1'b1;
    FrmAlignDone = 1'b1;
    cyc(P, P, 0);
    for (int i = 1; i < 72; i++) cyc(P, P, 0);
    chk("lock early", {31'h0, DatLocked}, 32'h0);
    cyc(P, P, 1);
    chk("lock locked", {31'h0, DatLocked}, 32'h1);
    chk("lock valid", {31'h0, DatValid}, 32'h1);
    chk("lock err", {30'h0, DatErr}, 32'h0);

    for (int i = 0; i < 5; i++) cyc(14'h1234, P, 1);
    chk("run errcnt", {16'h0, DatErrCnt}, 32'd5);
    chk("run err", {30'h0, DatErr}, 32'h1);
    chk("run valid", {31'h0, DatValid}, 32'h1);
    cyc(P, P, 1);
    chk("run clean errcnt", {16'h0, DatErrCnt}, 32'd5);

    FrmAlignDone = 1'b0;
    cyc(P, P, 0);
    chk("drop valid", {31'h0, DatValid}, 32'h0);
    chk("drop locked", {31'h0, DatLocked}, 32'h0);
    chk("drop errcnt", {16'h0, DatErrCnt}, 32'd5);
    chk("drop err", {30'h0, DatErr}, 32'h1);
    cyc(P, P, 0);

    FrmAlignDone = 1'b1;
    cyc(P, P, 0);
    chk("settle clr err", {30'h0, DatErr}, 32'h0);
    chk("settle clr errcnt", {16'h0, DatErrCnt}, 32'h0);
    repeat (8) cyc(P, P, 0);
    repeat (40) cyc(P, P, 0);
    cyc(P, 14'h0000, 0);
    chk("check miss err", {30'h0, DatErr}, 32'h2);
    chk("check miss locked", {31'h0, DatLocked}, 32'h0);
    repeat (63) cyc(P, P, 0);
    chk("relock early", {31'h0, DatLocked}, 32'h0);
    cyc(P, P, 1);
    chk("relock locked", {31'h0, DatLocked}, 32'h1);
    chk("relock errcnt", {16'h0, DatErrCnt}, 32'h0);

    for (int i = 0; i < 65538; i++) begin
      cyc(14'h0000, P, 1);
      if (i == 65533)
        chk("errcnt near full", {16'h0, DatErrCnt}, 32'hFFFE);
    end
    chk("errcnt saturate", {16'h0, DatErrCnt}, 32'hFFFF);
    chk("sat err", {30'h0, DatErr}, 32'h3);
    chk("sat valid", {31'h0, DatValid}, 32'h1);

    FrmAlignDone = 1'b0;
    cyc(P, P, 0);
    chk("drop2 locked", {31'h0, DatLocked}, 32'h0);
    chk("drop2 errcnt", {16'h0, DatErrCnt}, 32'hFFFF);
    DatPatMode   = 1'b0;
    FrmAlignDone = 1'b1;
    cyc(P, P, 0);
    repeat (7) cyc(P, P, 0);
    chk("normal early", {31'h0, DatLocked}, 32'h0);
    cyc(14'h1111, 14'h2222, 1);
    chk("normal locked", {31'h0, DatLocked}, 32'h1);
    for (int i = 0; i < 8; i++) cyc(vals[i], vals[7-i], 1);
    chk("normal errcnt", {16'h0, DatErrCnt}, 32'h0);

    FrmBitslip = 1'b1;
    #1;
    chk("run bitslip", {30'h0, DatBitslip}, 32'h3);
    cyc(P, P, 0);
    chk("bitslip exit", {31'h0, DatLocked}, 32'h0);
    FrmBitslip = 1'b0;
    cyc(P, P, 0);
    repeat (7) cyc(P, P, 0);
    cyc(14'h0F0F, 14'h3030, 1);
    chk("realign locked", {31'h0, DatLocked}, 32'h1);

    DatRst     = 1'b1;
    FrmBitslip = 1'b1;
    cyc(P, P, 0);
    chk("midrst bitslip", {30'h0, DatBitslip}, 32'h0);
    chk("midrst locked", {31'h0, DatLocked}, 32'h0);
    chk("midrst valid", {31'h0, DatValid}, 32'h0);
    chk("midrst sample", {4'h0, DatSample}, 32'h0);
    chk("midrst errcnt", {16'h0, DatErrCnt}, 32'h0);
    DatRst       = 1'b0;
    FrmBitslip   = 1'b0;
    FrmAlignDone = 1'b0;
    tick();

    chk("queue drained", expQ.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
